// File: rtl/rect_filler_if.sv
// Command and memory-port bundle for rect_filler.
// The slave side is the filler itself. The master side is whatever issues
// rectangles and owns the MIG address/write-data FIFOs.
interface rect_filler_if #(
    parameter int COORD_W = 10
);
    // Command handshake
    logic               valid;
    logic               ready;
    logic [23:0]        color;
    logic [COORD_W-1:0] x0;
    logic [COORD_W-1:0] y0;
    logic [COORD_W-1:0] x1;
    logic [COORD_W-1:0] y1;

    // MIG address FIFO
    logic               af_full;
    logic               af_wr_en;
    logic [30:0]        af_addr_din;

    // MIG write-data FIFO
    logic               wdf_full;
    logic               wdf_wr_en;
    logic [127:0]       wdf_din;
    logic [15:0]        wdf_mask_din;

    modport master (
        output valid, color, x0, y0, x1, y1, af_full, wdf_full,
        input  ready, af_wr_en, af_addr_din, wdf_wr_en, wdf_din, wdf_mask_din
    );

    modport slave (
        input  valid, color, x0, y0, x1, y1, af_full, wdf_full,
        output ready, af_wr_en, af_addr_din, wdf_wr_en, wdf_din, wdf_mask_din
    );
endinterface

// File: rtl/rect_filler.sv
// Rectangle filler: paints an axis-aligned, frame-clipped rectangle with one
// colour by writing 8-pixel blocks (one address push, two data words) to the
// DDR frame buffer. Byte masks protect pixels outside the rectangle in the
// partially covered blocks at the left and right edges.
module rect_filler #(
    parameter int          FRAME_W    = 800,
    parameter int          FRAME_H    = 600,
    parameter int          COORD_W    = 10,
    parameter logic [30:0] FB_BASE    = 31'h0010_0000,
    parameter int          LINE_SHIFT = 10
) (
    input  logic         clk,
    input  logic         rst,
    rect_filler_if.slave bus
);
    // One extra bit so that xb + 8 and y + 1 never wrap.
    localparam int CW = COORD_W + 1;
    typedef logic [CW-1:0] coord_t;

    localparam coord_t X_MAX = coord_t'(FRAME_W - 1);
    localparam coord_t Y_MAX = coord_t'(FRAME_H - 1);

    typedef enum logic [1:0] {IDLE, CHECK, ADDR, DATA1} state_t;

    state_t       state;
    logic         ready_q;
    logic [23:0]  color_q;
    coord_t       x0_q, y0_q, cx1_q, cy1_q;
    coord_t       xb_q, y_q;
    logic [30:0]  addr_q;
    logic [127:0] din_q;
    logic [15:0]  mask_q;   // mask of the word currently presented
    logic [15:0]  mask1_q;  // word-1 mask of the current block, staged

    logic         af_fire, wdf1_fire;
    coord_t       in_x1, in_y1, clip_x1, clip_y1;
    coord_t       xb_first, xb_last, nxt_xb, nxt_y;
    logic         last_in_row, last_blk, empty;
    logic [15:0]  nxt_mask0, nxt_mask1;
    logic [30:0]  nxt_addr;

    // Mask for four consecutive pixels starting at base: a pixel outside
    // [lo, hi] has all four of its bytes suppressed.
    function automatic logic [15:0] word_mask(coord_t base, coord_t lo, coord_t hi);
        logic [15:0] m;
        coord_t      px;
        m = '0;
        for (int k = 0; k < 4; k++) begin
            px = base + coord_t'(k);
            m[4*k +: 4] = {4{(px < lo) || (px > hi)}};
        end
        return m;
    endfunction

    // FIFO pushes are combinational so a push never costs a cycle of latency.
    assign af_fire   = (state == ADDR) && !bus.af_full && !bus.wdf_full;
    assign wdf1_fire = (state == DATA1) && !bus.wdf_full;

    assign bus.af_wr_en     = af_fire;
    assign bus.wdf_wr_en    = af_fire || wdf1_fire;
    assign bus.ready        = ready_q;
    assign bus.af_addr_din  = addr_q;
    assign bus.wdf_din      = din_q;
    assign bus.wdf_mask_din = mask_q;

    // Clip incoming corners and work out the block that will be issued next.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so no path can infer a latch.
        in_x1       = coord_t'(bus.x1);
        in_y1       = coord_t'(bus.y1);
        clip_x1     = (in_x1 > X_MAX) ? X_MAX : in_x1;
        clip_y1     = (in_y1 > Y_MAX) ? Y_MAX : in_y1;
        xb_first    = {x0_q[CW-1:3], 3'b000};
        xb_last     = {cx1_q[CW-1:3], 3'b000};
        last_in_row = (xb_q == xb_last);
        last_blk    = last_in_row && (y_q == cy1_q);
        empty       = (x0_q > cx1_q) || (y0_q > cy1_q);
        nxt_xb      = xb_q + coord_t'(8);
        nxt_y       = y_q;
        if (state == CHECK) begin
            nxt_xb = xb_first;
            nxt_y  = y0_q;
        end else if (last_in_row) begin
            nxt_xb = xb_first;
            nxt_y  = y_q + coord_t'(1);
        end
        nxt_addr  = FB_BASE + (31'(nxt_y) << LINE_SHIFT) + 31'(nxt_xb);
        nxt_mask0 = word_mask(nxt_xb, x0_q, cx1_q);
        nxt_mask1 = word_mask(nxt_xb + coord_t'(4), x0_q, cx1_q);
    end

    // Command FSM; output buses are registered and only change when a block
    // is loaded or word 0 is accepted, so they stay put while stalled.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            state   <= IDLE;
            ready_q <= 1'b1;
            color_q <= '0;
            x0_q    <= '0;
            y0_q    <= '0;
            cx1_q   <= '0;
            cy1_q   <= '0;
            xb_q    <= '0;
            y_q     <= '0;
            addr_q  <= '0;
            din_q   <= '0;
            mask_q  <= '1;
            mask1_q <= '1;
        end else begin
            unique case (state)
                IDLE: begin
                    if (bus.valid) begin
                        color_q <= bus.color;
                        x0_q    <= coord_t'(bus.x0);
                        y0_q    <= coord_t'(bus.y0);
                        cx1_q   <= clip_x1;
                        cy1_q   <= clip_y1;
                        ready_q <= 1'b0;
                        state   <= CHECK;
                    end
                end
                CHECK: begin
                    if (empty) begin
                        ready_q <= 1'b1;
                        state   <= IDLE;
                    end else begin
                        xb_q    <= nxt_xb;
                        y_q     <= nxt_y;
                        addr_q  <= nxt_addr;
                        mask_q  <= nxt_mask0;
                        mask1_q <= nxt_mask1;
                        din_q   <= {4{8'h00, color_q}};
                        state   <= ADDR;
                    end
                end
                ADDR: begin
                    if (af_fire) begin
                        mask_q <= mask1_q;
                        state  <= DATA1;
                    end
                end
                DATA1: begin
                    if (wdf1_fire) begin
                        if (last_blk) begin
                            ready_q <= 1'b1;
                            state   <= IDLE;
                        end else begin
                            xb_q    <= nxt_xb;
                            y_q     <= nxt_y;
                            addr_q  <= nxt_addr;
                            mask_q  <= nxt_mask0;
                            mask1_q <= nxt_mask1;
                            state   <= ADDR;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
